// File: rtl/multicycle_ctrl.sv
// Shared types for the RV32 core plus its multi-cycle sequencer (FETCH/DECODE/EXECUTE/MEM/WB).
// Latency 2-5 cycles per instruction; stalls in FETCH/MEM with requests held until the memory responds.
package cpu_pkg;

  typedef enum logic [6:0] {
    OPCODE_LOAD     = 7'b0000011,
    OPCODE_MISC_MEM = 7'b0001111,
    OPCODE_OP_IMM   = 7'b0010011,
    OPCODE_AUIPC    = 7'b0010111,
    OPCODE_STORE    = 7'b0100011,
    OPCODE_OP       = 7'b0110011,
    OPCODE_LUI      = 7'b0110111,
    OPCODE_BRANCH   = 7'b1100011,
    OPCODE_JALR     = 7'b1100111,
    OPCODE_JAL      = 7'b1101111,
    OPCODE_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  typedef enum logic {SRC_A_RS1, SRC_A_PC} src_a_sel_t;
  typedef enum logic {SRC_B_RS2, SRC_B_IMM} src_b_sel_t;

  typedef struct packed {
    alu_op_t    alu_op;
    src_a_sel_t src_a_sel;
    src_b_sel_t src_b_sel;
    logic       reg_write;
  } control_signals_t;

endpackage

module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_o,
  input  logic             imem_valid_i,
  input  logic [31:0]      imem_instr_i,
  output logic [31:0]      instr_o,
  output control_signals_t ctrl_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ready_i,
  output logic             pc_we_o,
  output logic             halted_o,
  output logic [31:0]      instret_o
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam control_signals_t CTRL_IDLE = '{
    alu_op:    ALU_NOP,
    src_a_sel: SRC_A_RS1,
    src_b_sel: SRC_B_RS2,
    reg_write: 1'b0
  };

  state_t           state_q, state_d;
  logic [31:0]      ir_q;
  logic [31:0]      instret_q;
  control_signals_t ctrl_q;
  logic             is_mem_q, is_store_q;

  control_signals_t dec_ctrl;
  logic             dec_mem, dec_store, dec_fence, dec_illegal;
  logic [2:0]       funct3;
  logic             funct7_b5;
  alu_op_t          f3_alu;
  logic             f3_ok;
  logic             pc_we;

  assign funct3    = ir_q[14:12];
  assign funct7_b5 = ir_q[30];

  // funct3 -> ALU op mapping shared by OP and OP_IMM
  always_comb begin
    f3_alu = ALU_NOP;
    f3_ok  = 1'b1;
    case (funct3)
      3'b000:  f3_alu = ALU_ADD;
      3'b100:  f3_alu = ALU_XOR;
      3'b110:  f3_alu = ALU_OR;
      3'b111:  f3_alu = ALU_AND;
      default: f3_ok  = 1'b0;
    endcase
  end

  always_comb begin
    dec_ctrl    = CTRL_IDLE;
    dec_mem     = 1'b0;
    dec_store   = 1'b0;
    dec_fence   = 1'b0;
    dec_illegal = 1'b0;
    case (ir_q[6:0])
      OPCODE_OP: begin
        if (funct7_b5) begin
          if (funct3 == 3'b000) dec_ctrl.alu_op = ALU_SUB;
          else                  dec_illegal     = 1'b1;
        end else if (f3_ok) begin
          dec_ctrl.alu_op = f3_alu;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPCODE_OP_IMM: begin
        dec_ctrl.src_b_sel = SRC_B_IMM;
        if (f3_ok) dec_ctrl.alu_op = f3_alu;
        else       dec_illegal     = 1'b1;
      end
      OPCODE_LOAD, OPCODE_STORE: begin
        if (funct3 == 3'b010) begin
          dec_ctrl.alu_op    = ALU_ADD;
          dec_ctrl.src_b_sel = SRC_B_IMM;
          dec_mem            = 1'b1;
          dec_store          = (ir_q[6:0] == OPCODE_STORE);
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPCODE_MISC_MEM: dec_fence   = 1'b1;
      default:         dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    pc_we      = 1'b0;
    halted_o   = 1'b0;
    ctrl_o     = CTRL_IDLE;
    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_valid_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_HALT;
        end else if (dec_fence) begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        ctrl_o  = ctrl_q;
        state_d = is_mem_q ? S_MEM : S_WB;
      end
      S_MEM: begin
        ctrl_o     = ctrl_q;
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store_q;
        if (dmem_ready_i) begin
          pc_we   = is_store_q;
          state_d = is_store_q ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        ctrl_o           = ctrl_q;
        ctrl_o.reg_write = 1'b1;
        pc_we            = 1'b1;
        state_d          = S_FETCH;
      end
      S_HALT:  halted_o = 1'b1;
      default: state_d  = S_FETCH;
    endcase
    // Reset is synchronous, so the current state is still live in the reset cycle; mask everything.
    if (rst) begin
      imem_req_o = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      pc_we      = 1'b0;
      halted_o   = 1'b0;
      ctrl_o     = CTRL_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      ctrl_q     <= CTRL_IDLE;
      is_mem_q   <= 1'b0;
      is_store_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem_valid_i) ir_q <= imem_instr_i;
      if (state_q == S_DECODE) begin
        ctrl_q     <= dec_ctrl;
        is_mem_q   <= dec_mem;
        is_store_q <= dec_store;
      end
      if (pc_we) instret_q <= instret_q + 32'd1;
    end
  end

  assign pc_we_o   = pc_we;
  assign instr_o   = ir_q;
  assign instret_o = instret_q;

endmodule
